// File: rtl/stream_record_player.sv
// stream_record_player
// AXI4-Stream capture/replay buffer. Records one packet from the input stream
// into on-chip memory, then replays it on the output stream on command.
// Optional looped replay is enabled by defining STREAM_LOOP_EN; without it the
// loop input is accepted but ignored and every replay is single-shot.
module stream_record_player #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  record,
    input  logic                  play,
    input  logic                  loop,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   stored_len,
    output logic                  overflow,
    output logic                  busy
);

    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

`ifdef STREAM_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
    logic loop_req;
    assign loop_req = loop;
`else
    localparam bit LOOP_EN = 1'b0;
    logic loop_req;
    // loop has no effect in the single-shot build
    assign loop_req = 1'b0 & loop;
`endif

    typedef enum logic [1:0] {
        REC_IDLE,
        REC_CAPTURE,
        REC_DONE
    } rec_state_t;

    typedef enum logic [1:0] {
        PLAY_IDLE,
        PLAY_RUN,
        PLAY_DONE
    } play_state_t;

    rec_state_t             rec_state, rec_next;
    play_state_t            play_state, play_next;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH:0]    wr_ptr;
    logic [ADDR_WIDTH:0]    rd_ptr;
    logic [ADDR_WIDTH:0]    last_ptr;

    logic                   in_accept;
    logic                   out_hs;

    // Read pipeline: stage 1 is the registered memory read, stage 2 the output register
    logic [DATA_WIDTH-1:0]  rdata;
    logic                   rlast;
    logic                   rvalid;
    logic                   load_out;
    logic                   adv_rd;
    logic                   issue;

    assign in_ready  = (rec_state == REC_CAPTURE);
    assign in_accept = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign busy      = !((rec_state == REC_IDLE) && (play_state == PLAY_IDLE));
    assign last_ptr  = stored_len - PTR_ONE;

    // The output register may load when empty or when its beat is being taken;
    // the read stage may advance when empty or when it can hand over its beat.
    assign load_out  = !out_valid || out_ready;
    assign adv_rd    = !rvalid || load_out;
    assign issue     = (play_state == PLAY_RUN) && adv_rd && (rd_ptr < stored_len);

    // Recorder next-state logic
    always_comb begin
        // NOTE: next state defaults to the current state before any branch so no latch is inferred.
        rec_next = rec_state;
        if (!record) begin
            rec_next = REC_IDLE;
        end else begin
            case (rec_state)
                REC_IDLE: begin
                    if (play_state == PLAY_IDLE) rec_next = REC_CAPTURE;
                end
                REC_CAPTURE: begin
                    if (in_accept && (in_last || (wr_ptr == LAST_IDX))) rec_next = REC_DONE;
                end
                REC_DONE: rec_next = REC_DONE;
                default:  rec_next = REC_IDLE;
            endcase
        end
    end

    // Recorder state, write pointer, stored length and overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rec_state  <= REC_IDLE;
            wr_ptr     <= '0;
            stored_len <= '0;
            overflow   <= 1'b0;
        end else begin
            rec_state <= rec_next;
            if ((rec_state != REC_CAPTURE) && (rec_next == REC_CAPTURE)) begin
                wr_ptr   <= '0;
                overflow <= 1'b0;
            end else if (in_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            // Leaving capture (done, full or aborted) latches the beats accepted so far,
            // including a beat accepted on this very edge.
            if ((rec_state == REC_CAPTURE) && (rec_next != REC_CAPTURE)) begin
                stored_len <= wr_ptr + {{ADDR_WIDTH{1'b0}}, in_accept};
                if (in_accept && (wr_ptr == LAST_IDX) && !in_last) overflow <= 1'b1;
            end
        end
    end

    // Player next-state logic
    always_comb begin
        play_next = play_state;
        if (!play) begin
            play_next = PLAY_IDLE;
        end else begin
            case (play_state)
                PLAY_IDLE: begin
                    // A pending or active recording always takes priority over playback
                    if (!record && (rec_state != REC_CAPTURE)) begin
                        play_next = (stored_len == '0) ? PLAY_DONE : PLAY_RUN;
                    end
                end
                PLAY_RUN: begin
                    if (out_hs && out_last && !loop_req) play_next = PLAY_DONE;
                end
                PLAY_DONE: play_next = PLAY_DONE;
                default:   play_next = PLAY_IDLE;
            endcase
        end
    end

    // Player state, read pointer and the two-stage output pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            play_state <= PLAY_IDLE;
            rd_ptr     <= '0;
            rvalid     <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
        end else begin
            play_state <= play_next;
            if (play_next != PLAY_RUN) begin
                // Stopping or finishing empties the pipeline, dropping any
                // beat fetched ahead for a next loop iteration.
                rd_ptr    <= '0;
                rvalid    <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                // In the loop build the read pointer wraps ahead of time so
                // iterations run back-to-back; a dropped loop flushes it.
                if (issue) rd_ptr <= (LOOP_EN && (rd_ptr == last_ptr)) ? '0 : rd_ptr + PTR_ONE;
                if (adv_rd) rvalid <= issue;
                if (load_out) begin
                    out_valid <= rvalid;
                    out_last  <= rvalid & rlast;
                    if (rvalid) out_data <= rdata;
                end
            end
        end
    end

    // Packet buffer: write on accepted input beats, registered read for playback
    always_ff @(posedge clk) begin
        // NOTE: the buffer is deliberately not reset; stored_len=0 makes stale contents unreachable.
        if (in_accept) mem[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
        if (issue) begin
            rdata <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            rlast <= (rd_ptr == last_ptr);
        end
    end

endmodule

// File: tb/tb_stream_record_player.sv
// tb_stream_record_player
// Scoreboard bench for stream_record_player. Stimulus records packets and
// pushes the expected replay into a queue; a monitor pops and compares on
// every output handshake and checks AXI-S hold rules while stalled.
`timescale 1ns/1ps
module tb_stream_record_player;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
`ifdef STREAM_LOOP_EN
    localparam bit LOOP_MODEL = 1'b1;
`else
    localparam bit LOOP_MODEL = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          record;
    logic          play;
    logic          loop;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [AW:0]   stored_len;
    logic          overflow;
    logic          busy;

    stream_record_player #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .record     (record),
        .play       (play),
        .loop       (loop),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .stored_len (stored_len),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] stored_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int ready_mode = 0;
    int rdy_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference replay of the stored packet: every beat, last only on the final one
    task automatic push_packet();
        beat_t b;
        for (int i = 0; i < stored_q.size(); i++) begin
            b.data = stored_q[i];
            b.last = (i == stored_q.size() - 1);
            exp_q.push_back(b);
        end
    endtask

    // Sink readiness: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1
    always @(posedge clk) begin
        #1;
        rdy_cnt++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = ((rdy_cnt % 4) == 0) || ((rdy_cnt % 4) == 3);
        endcase
    end

    // Monitor: scoreboard pops on handshakes, hold rule checked after stalls
    logic          prev_stall = 1'b0;
    logic          prev_play  = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && prev_play) begin
                check("hold_valid", out_valid, 1);
                if (out_valid) begin
                    check("hold_data", out_data, prev_data);
                    check("hold_last", out_last, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat (t=%0t)",
                             out_data, out_last, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                    if (LOOP_MODEL && e.last && loop) push_packet();
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_play  = play;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int t;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
        end
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) check("in_ready_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Model: accepted = first min(n, DEPTH) beats; overflow when the buffer
    // fills before a beat carrying last is accepted.
    task automatic record_packet(input int n, input bit with_last, input int base, input bit with_play);
        logic [DW-1:0] pkt[$];
        int            acc;
        bit            exp_ovf;
        for (int i = 0; i < n; i++) pkt.push_back((base < 0) ? DW'($urandom) : DW'(base + i));
        acc     = (n < DEPTH) ? n : DEPTH;
        exp_ovf = with_last ? (n > DEPTH) : (n >= DEPTH);
        record = 1'b1;
        if (with_play) play = 1'b1;
        tick();
        check("rec_in_ready", in_ready, 1);
        if (with_play) begin
            repeat (3) begin
                check("rec_play_no_valid", out_valid, 0);
                check("rec_play_busy", busy, 1);
                tick();
            end
        end
        for (int i = 0; i < acc; i++) send_beat(pkt[i], with_last && (i == n - 1));
        if (n > acc) begin
            in_data  = pkt[acc];
            in_valid = 1'b1;
            repeat (3) begin
                check("full_in_ready", in_ready, 0);
                tick();
            end
            in_valid = 1'b0;
        end
        record = 1'b0;
        if (with_play) play = 1'b0;
        tick();
        tick();
        check("stored_len", stored_len, acc);
        check("overflow", overflow, exp_ovf);
        check("idle_in_ready", in_ready, 0);
        check("idle_out_valid", out_valid, 0);
        stored_q.delete();
        for (int i = 0; i < acc; i++) stored_q.push_back(pkt[i]);
    endtask

    task automatic start_play();
        push_packet();
        play = 1'b1;
        if (stored_q.size() == 0) begin
            repeat (4) begin
                tick();
                check("empty_no_valid", out_valid, 0);
            end
            check("empty_done_busy", busy, 1);
        end else begin
            tick();
            check("latency_c1", out_valid, 0);
            tick();
            check("latency_c2", out_valid, 0);
            tick();
            check("latency_first", out_valid, 1);
        end
    endtask

    task automatic finish_play(input int stop_after);
        int t;
        if (stop_after > 0 && stored_q.size() != 0) begin
            repeat (stop_after) tick();
            play = 1'b0;
            tick();
            check("stop_out_valid", out_valid, 0);
            exp_q.delete();
        end else begin
            t = 0;
            while (exp_q.size() != 0 && t < 2000) begin
                tick();
                t++;
            end
            check("drain_left", exp_q.size(), 0);
            exp_q.delete();
            tick();
            check("done_out_valid", out_valid, 0);
            check("done_busy", busy, 1);
            check("done_stored_len", stored_len, stored_q.size());
            play = 1'b0;
        end
        tick();
        check("idle_busy", busy, 0);
    endtask

    initial begin
        reset    = 1'b1;
        record   = 1'b0;
        play     = 1'b0;
        loop     = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_stored_len", stored_len, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Nothing stored: playback finishes without issuing a beat
        start_play();
        finish_play(0);

        // Five-beat packet, replay at full rate
        ready_mode = 0;
        record_packet(5, 1'b1, 'h11, 1'b0);
        start_play();
        finish_play(0);

        // Packet without last overruns the buffer
        record_packet(DEPTH + 2, 1'b0, 'h40, 1'b0);
        start_play();
        finish_play(0);

        // Same buffer replayed against a 1,0,0,1 ready pattern
        ready_mode = 2;
        start_play();
        finish_play(0);

        // record and play raised together: recording wins
        ready_mode = 0;
        record_packet(3, 1'b1, 'h60, 1'b1);
        start_play();
        finish_play(0);

        // Asynchronous reset in the middle of playback
        ready_mode = 1;
        record_packet(6, 1'b1, -1, 1'b0);
        start_play();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_stored_len", stored_len, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_last", out_last, 0);
        exp_q.delete();
        stored_q.delete();
        play = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("postrst_stored_len", stored_len, 0);

        // Looped replay (single-shot when the loop feature is absent)
        ready_mode = 0;
        record_packet(3, 1'b1, 'hA0, 1'b0);
        loop = 1'b1;
        start_play();
        for (int k = 1; k < 9; k++) begin
            tick();
            check("loop_valid", out_valid, (LOOP_MODEL || k < 3) ? 1 : 0);
        end
        loop = 1'b0;
        finish_play(0);

        // Randomised record/replay rounds
        for (int r = 0; r < 12; r++) begin
            int n;
            bit wl;
            int stop;
            wl   = 1'($urandom_range(0, 1));
            n    = wl ? $urandom_range(1, DEPTH + 2) : $urandom_range(0, DEPTH + 2);
            loop = LOOP_MODEL ? 1'b0 : 1'($urandom_range(0, 1));
            record_packet(n, wl, -1, 1'b0);
            ready_mode = $urandom_range(0, 2);
            start_play();
            stop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            finish_play(stop);
        end
        loop = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
